// File: rtl/gps_correlator_chan.sv
// ============================================================================
//  Module   : gps_correlator_chan
//  Purpose  : Single GPS receive channel. Removes the carrier from a 3-bit I/Q
//             baseband stream with an internal NCO, removes one selected C/A
//             code and integrates prompt I/Q over each 1023-chip code epoch.
//             Epoch sums are offered on a valid/ready port.
//  Ports    : clk, rstn            - clock, asynchronous active-low reset
//             enable               - 0 holds the channel idle, 0->1 starts
//             freq                 - NCO phase increment per sample
//             ca_sel               - C/A code select (0..35 = SV1..SV36)
//             code_phase           - starting chip, sampled while enable=0
//             real_in, imag_in     - signed 3-bit baseband sample
//             acc_i, acc_q         - prompt I/Q epoch sums
//             acc_valid, acc_ready - result handshake
//             overrun              - sticky: a pending result was overwritten
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gps_correlator_chan #(
    parameter int SAMPLES_PER_CHIP = 100,
    parameter int CODE_LEN         = 1023,
    parameter int ACC_W            = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic [31:0]             freq,
    input  logic [5:0]              ca_sel,
    input  logic [9:0]              code_phase,
    input  logic [2:0]              real_in,
    input  logic [2:0]              imag_in,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic                    overrun
);

    localparam int NUM_SV    = 36;
    localparam int ROM_DEPTH = 1023;
    localparam int SAMP_W    = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [9:0]        CHIP_LAST = 10'(CODE_LEN - 1);

    // G2 output taps (register stages) selecting each satellite's code phase.
    localparam int TAP_A [NUM_SV] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,
                                      3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
    localparam int TAP_B [NUM_SV] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,
                                      6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};

    // Builds the C/A ROM contents at elaboration: entry k holds chip k of all
    // 36 codes, bit s = SV(s+1). The loop is split 31x33 to cover 1023 chips.
    function automatic logic [NUM_SV*ROM_DEPTH-1:0] ca_table_gen();
        logic [10:1]                   g1;
        logic [10:1]                   g2;
        logic [NUM_SV*ROM_DEPTH-1:0]   t;
        int                            k;
        g1 = '1;
        g2 = '1;
        t  = '0;
        k  = 0;
        for (int a = 0; a < 31; a++) begin
            for (int b = 0; b < 33; b++) begin
                for (int s = 0; s < NUM_SV; s++) begin
                    t[k*NUM_SV + s] = g1[10] ^ g2[TAP_A[s]] ^ g2[TAP_B[s]];
                end
                g1 = {g1[9:1], g1[3] ^ g1[10]};
                g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [NUM_SV*ROM_DEPTH-1:0] CA_TABLE = ca_table_gen();

    // ------------------------------------------------------------------
    // Chip / sample counters and carrier NCO
    // ------------------------------------------------------------------
    logic [SAMP_W-1:0] samp_cnt_q;
    logic [9:0]        chip_cnt_q;
    logic [31:0]       nco_q;
    logic              w_chip_wrap;
    logic              w_epoch_end;

    assign w_chip_wrap = (samp_cnt_q == SAMP_LAST);
    assign w_epoch_end = w_chip_wrap && (chip_cnt_q == CHIP_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samp_cnt_q <= '0;
            chip_cnt_q <= '0;
            nco_q      <= '0;
        end else if (!enable) begin
            samp_cnt_q <= '0;
            chip_cnt_q <= code_phase;
            nco_q      <= '0;
        end else begin
            nco_q <= nco_q + freq;
            if (w_chip_wrap) begin
                samp_cnt_q <= '0;
                chip_cnt_q <= (chip_cnt_q == CHIP_LAST) ? 10'd0 : chip_cnt_q + 10'd1;
            end else begin
                samp_cnt_q <= samp_cnt_q + SAMP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: ROM read. Sample, NCO phase and epoch flag are registered
    // alongside so every sample stays paired with the chip of its own cycle.
    // ------------------------------------------------------------------
    logic [15:0] w_rom_idx;
    logic        w_sel_ok;
    logic        va_q, la_q, code_a_q;
    logic [2:0]  re_a_q, im_a_q, ph_a_q;

    assign w_rom_idx = 16'(chip_cnt_q) * 16'(NUM_SV) + 16'(ca_sel);
    assign w_sel_ok  = (ca_sel < 6'(NUM_SV));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            va_q     <= 1'b0;
            la_q     <= 1'b0;
            code_a_q <= 1'b0;
            re_a_q   <= '0;
            im_a_q   <= '0;
            ph_a_q   <= '0;
        end else begin
            va_q     <= enable;
            la_q     <= w_epoch_end;
            code_a_q <= w_sel_ok ? CA_TABLE[w_rom_idx] : 1'b0;
            re_a_q   <= real_in;
            im_a_q   <= imag_in;
            ph_a_q   <= nco_q[31:29];
        end
    end

    // ------------------------------------------------------------------
    // Stage B: carrier wipe-off (8-phase cos/sin, amplitudes +-1/+-3)
    // ------------------------------------------------------------------
    logic signed [5:0] w_cos, w_sin, w_re, w_im, w_mi, w_mq;

    always_comb begin
        w_cos = 6'sd0;
        w_sin = 6'sd0;
        case (ph_a_q)
            3'd0: begin w_cos =  6'sd3; w_sin =  6'sd1; end
            3'd1: begin w_cos =  6'sd1; w_sin =  6'sd3; end
            3'd2: begin w_cos = -6'sd1; w_sin =  6'sd3; end
            3'd3: begin w_cos = -6'sd3; w_sin =  6'sd1; end
            3'd4: begin w_cos = -6'sd3; w_sin = -6'sd1; end
            3'd5: begin w_cos = -6'sd1; w_sin = -6'sd3; end
            3'd6: begin w_cos =  6'sd1; w_sin = -6'sd3; end
            default: begin w_cos = 6'sd3; w_sin = -6'sd1; end
        endcase
    end

    assign w_re = {{3{re_a_q[2]}}, re_a_q};
    assign w_im = {{3{im_a_q[2]}}, im_a_q};
    assign w_mi = w_re * w_cos + w_im * w_sin;
    assign w_mq = w_im * w_cos - w_re * w_sin;

    logic signed [5:0] mi_b_q, mq_b_q;
    logic              vb_q, lb_q, code_b_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mi_b_q   <= '0;
            mq_b_q   <= '0;
            vb_q     <= 1'b0;
            lb_q     <= 1'b0;
            code_b_q <= 1'b0;
        end else begin
            mi_b_q   <= w_mi;
            mq_b_q   <= w_mq;
            vb_q     <= va_q & enable;
            lb_q     <= la_q;
            code_b_q <= code_a_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage C: code wipe-off (chip 0 -> +1, chip 1 -> -1)
    // ------------------------------------------------------------------
    logic signed [5:0] pi_c_q, pq_c_q;
    logic              vc_q, lc_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pi_c_q <= '0;
            pq_c_q <= '0;
            vc_q   <= 1'b0;
            lc_q   <= 1'b0;
        end else begin
            pi_c_q <= code_b_q ? -mi_b_q : mi_b_q;
            pq_c_q <= code_b_q ? -mq_b_q : mq_b_q;
            vc_q   <= vb_q & enable;
            lc_q   <= lb_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage D: integrate and dump. The epoch's last product is folded into
    // the dumped sum, so the running sums restart cleanly at zero.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] sum_i_q, sum_q_q;
    logic signed [ACC_W-1:0] sum_i_d, sum_q_d;

    assign sum_i_d = sum_i_q + {{(ACC_W-6){pi_c_q[5]}}, pi_c_q};
    assign sum_q_d = sum_q_q + {{(ACC_W-6){pq_c_q[5]}}, pq_c_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_i_q   <= '0;
            sum_q_q   <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            acc_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (!enable) begin
            sum_i_q   <= '0;
            sum_q_q   <= '0;
            acc_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (acc_valid && acc_ready) begin
                acc_valid <= 1'b0;
            end
            if (vc_q) begin
                if (lc_q) begin
                    acc_i     <= sum_i_d;
                    acc_q     <= sum_q_d;
                    sum_i_q   <= '0;
                    sum_q_q   <= '0;
                    acc_valid <= 1'b1;     // overrides the clear on coincident accept
                    if (acc_valid && !acc_ready) begin
                        overrun <= 1'b1;
                    end
                end else begin
                    sum_i_q <= sum_i_d;
                    sum_q_q <= sum_q_d;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gps_correlator_chan.sv
// ============================================================================
//  Module   : tb_gps_correlator_chan
//  Purpose  : Self-checking bench for gps_correlator_chan. A behavioural
//             channel model pushes each expected epoch sum (with its due
//             cycle) into a scoreboard queue; a monitor pops and compares
//             whenever acc_valid rises. Scenario tasks add direct checks.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gps_correlator_chan;

    localparam int SPC   = 3;
    localparam int CL    = 1023;
    localparam int AW    = 32;
    localparam int EPOCH = CL * SPC;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 enable;
    logic [31:0]          freq;
    logic [5:0]           ca_sel;
    logic [9:0]           code_phase;
    logic [2:0]           real_in;
    logic [2:0]           imag_in;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 overrun;

    always #5 clk = ~clk;

    gps_correlator_chan #(
        .SAMPLES_PER_CHIP (SPC),
        .CODE_LEN         (CL),
        .ACC_W            (AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .freq       (freq),
        .ca_sel     (ca_sel),
        .code_phase (code_phase),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .acc_i      (acc_i),
        .acc_q      (acc_q),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .overrun    (overrun)
    );

    typedef struct { int i; int q; int due; } exp_t;
    exp_t sb[$];

    bit ca_tb [36][CL];
    int COS_T [8] = '{3, 1, -1, -3, -3, -1, 1, 3};
    int SIN_T [8] = '{1, 3, 3, 1, -1, -3, -3, -1};
    int G2A   [36] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
    int G2B   [36] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_dumps = 0;
    int last_i, last_q, last_cyc;
    bit prev_valid = 1'b0;

    // model state
    int          m_chip, m_samp, m_ai, m_aq;
    logic [31:0] m_nco;
    int          mode;     // 0 constant, 1 matched to SV1, 2 random
    int          cr, ci;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every fresh result is compared against the model.
    always @(negedge clk) begin
        if (rstn && acc_valid && !prev_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: dump acc_i=%0d acc_q=%0d at cycle %0d, none expected",
                         acc_i, acc_q, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (acc_i !== e.i || acc_q !== e.q || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL sb_dump: got i=%0d q=%0d cyc=%0d, expected i=%0d q=%0d cyc=%0d",
                             acc_i, acc_q, cyc, e.i, e.q, e.due);
                end
            end
            last_i   = acc_i;
            last_q   = acc_q;
            last_cyc = cyc;
            n_dumps++;
        end
        prev_valid = rstn ? acc_valid : 1'b0;
    end

    task automatic gen_codes();
        for (int sv = 0; sv < 36; sv++) begin
            logic [9:0] g1, g2;   // bit 0 = stage 1
            g1 = '1;
            g2 = '1;
            for (int k = 0; k < CL; k++) begin
                bit f1, f2;
                ca_tb[sv][k] = g1[9] ^ g2[G2A[sv]-1] ^ g2[G2B[sv]-1];
                f1 = g1[2] ^ g1[9];
                f2 = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
                g1 = {g1[8:0], f1};
                g2 = {g2[8:0], f2};
            end
        end
    endtask

    // One clock: drive a sample at negedge, model its effect at the coming
    // edge, then return 1 time unit after that edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            int r, i, p, mi, mq, sg;
            @(negedge clk);
            case (mode)
                0: begin r = cr; i = ci; end
                1: begin r = ca_tb[0][m_chip] ? -3 : 3; i = 0; end
                default: begin
                    r = int'($urandom_range(0, 7)) - 4;
                    i = int'($urandom_range(0, 7)) - 4;
                end
            endcase
            real_in = 3'(r);
            imag_in = 3'(i);
            if (!rstn || !enable) begin
                m_chip = rstn ? int'(code_phase) : 0;
                m_samp = 0;
                m_nco  = '0;
                m_ai   = 0;
                m_aq   = 0;
            end else begin
                p  = int'(m_nco[31:29]);
                mi = r * COS_T[p] + i * SIN_T[p];
                mq = i * COS_T[p] - r * SIN_T[p];
                sg = ca_tb[ca_sel][m_chip] ? -1 : 1;
                m_ai += sg * mi;
                m_aq += sg * mq;
                if (m_chip == CL-1 && m_samp == SPC-1) begin
                    sb.push_back('{i: m_ai, q: m_aq, due: cyc + 4});
                    m_ai = 0;
                    m_aq = 0;
                end
                if (m_samp == SPC-1) begin
                    m_samp = 0;
                    m_chip = (m_chip == CL-1) ? 0 : m_chip + 1;
                end else begin
                    m_samp++;
                end
                m_nco = m_nco + freq;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dump(input int budget, output bit ok);
        int start;
        start = n_dumps;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            step(1);
            if (n_dumps != start) ok = 1'b1;
        end
    endtask

    task automatic restart(input int phase, input int md, input bit rdy);
        enable     = 1'b0;
        code_phase = 10'(phase);
        mode       = md;
        acc_ready  = rdy;
        step(2);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        int rel;
        rstn = 1'b0; enable = 1'b0; freq = '0; ca_sel = '0; code_phase = '0;
        acc_ready = 1'b0; mode = 0; cr = 3; ci = 0;
        step(4);
        n_tests += 4;
        if (acc_i !== 0)       begin n_fail++; $display("FAIL rst_acc_i: got %0d expected 0", acc_i); end
        if (acc_q !== 0)       begin n_fail++; $display("FAIL rst_acc_q: got %0d expected 0", acc_q); end
        if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", acc_valid); end
        if (overrun !== 1'b0)  begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        rstn = 1'b1;
        restart(0, 0, 1'b0);
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rst_pre_dump: no dump within budget, expected one"); end
        step(EPOCH / 2);
        #2 rstn = 1'b0;
        #1;
        n_tests += 3;
        if (acc_i !== 0 || acc_q !== 0) begin
            n_fail++; $display("FAIL rst_async_acc: got i=%0d q=%0d expected 0 0", acc_i, acc_q);
        end
        if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", acc_valid); end
        if (overrun !== 1'b0)  begin n_fail++; $display("FAIL rst_async_ovr: got %b expected 0", overrun); end
        sb.delete();
        acc_ready = 1'b1;
        step(3);
        rstn = 1'b1;
        rel = cyc;
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok || last_cyc - rel != EPOCH + 3) begin
            n_fail++;
            $display("FAIL rst_first_dump: dump after %0d cycles (ok=%0b) expected %0d", last_cyc - rel, ok, EPOCH + 3);
        end
    endtask

    task automatic test_constant();
        bit ok;
        int en;
        cr = 3; ci = 0; freq = '0; ca_sel = 6'd0;
        restart(0, 0, 1'b1);
        en = cyc;
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok || last_i != -9*SPC || last_q != 3*SPC || last_cyc - en != EPOCH + 3) begin
            n_fail++;
            $display("FAIL const_epoch: got i=%0d q=%0d lat=%0d, expected i=%0d q=%0d lat=%0d",
                     last_i, last_q, last_cyc - en, -9*SPC, 3*SPC, EPOCH + 3);
        end
    endtask

    task automatic test_matched();
        bit ok;
        freq = '0; ca_sel = 6'd0;
        restart(0, 1, 1'b1);
        for (int e = 0; e < 2; e++) begin
            wait_dump(EPOCH + 20, ok);
            n_tests++;
            if (!ok || last_i != 9*EPOCH || last_q != -3*EPOCH) begin
                n_fail++;
                $display("FAIL matched_%0d: got i=%0d q=%0d expected i=%0d q=%0d",
                         e, last_i, last_q, 9*EPOCH, -3*EPOCH);
            end
        end
        step(100);
        ca_sel = 6'd1;   // mid-epoch switch, no restart
        wait_dump(EPOCH + 20, ok);
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok || last_i > 9*EPOCH/4 || last_i < -9*EPOCH/4) begin
            n_fail++;
            $display("FAIL cross_corr: got i=%0d expected |i| < %0d", last_i, 9*EPOCH/4);
        end
    endtask

    task automatic test_partial();
        bit ok;
        int en, first;
        freq = '0; ca_sel = 6'd0;
        restart(1022, 1, 1'b1);
        en = cyc;
        wait_dump(SPC + 20, ok);
        n_tests++;
        if (!ok || last_i != 9*SPC || last_q != -3*SPC || last_cyc - en != SPC + 3) begin
            n_fail++;
            $display("FAIL partial_first: got i=%0d q=%0d lat=%0d expected i=%0d q=%0d lat=%0d",
                     last_i, last_q, last_cyc - en, 9*SPC, -3*SPC, SPC + 3);
        end
        first = last_cyc;
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok || last_cyc - first != EPOCH) begin
            n_fail++;
            $display("FAIL partial_period: got spacing %0d expected %0d", last_cyc - first, EPOCH);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int ai, aq, k;
        exp_t e;
        freq = 32'h0123_4567; ca_sel = 6'd4;
        restart(0, 2, 1'b0);
        wait_dump(EPOCH + 20, ok);
        ai = last_i; aq = last_q;
        step(EPOCH / 2);
        n_tests++;
        if (overrun !== 1'b0 || acc_i !== ai || acc_q !== aq || acc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got i=%0d q=%0d v=%b ovr=%b expected i=%0d q=%0d v=1 ovr=0",
                     acc_i, acc_q, acc_valid, overrun, ai, aq);
        end
        k = 0;
        while ((sb.size() == 0 || cyc < sb[0].due + 1) && k < EPOCH) begin step(1); k++; end
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL bp_second: no second epoch expected after %0d cycles", k);
        end else begin
            e = sb.pop_front();
            if (overrun !== 1'b1 || acc_valid !== 1'b1 || acc_i !== e.i || acc_q !== e.q) begin
                n_fail++;
                $display("FAIL bp_overwrite: got i=%0d q=%0d v=%b ovr=%b expected i=%0d q=%0d v=1 ovr=1",
                         acc_i, acc_q, acc_valid, overrun, e.i, e.q);
            end
        end
        acc_ready = 1'b1;
        step(1);
        acc_ready = 1'b0;
        n_tests++;
        if (acc_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL bp_accept: got v=%b ovr=%b expected v=0 ovr=1", acc_valid, overrun);
        end
        step(5);
        enable = 1'b0;
        step(1);
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_coincident();
        bit ok;
        int k;
        exp_t e;
        freq = 32'h0badcafe; ca_sel = 6'd17;
        restart(500, 2, 1'b0);
        wait_dump(EPOCH + 20, ok);
        k = 0;
        while ((sb.size() == 0 || cyc < sb[0].due - 1) && k < EPOCH + 20) begin step(1); k++; end
        acc_ready = 1'b1;
        step(1);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL coinc_expect: no second epoch expected after %0d cycles", k);
        end else begin
            e = sb.pop_front();
            if (acc_valid !== 1'b1 || overrun !== 1'b0 || acc_i !== e.i || acc_q !== e.q) begin
                n_fail++;
                $display("FAIL coinc_load: got i=%0d q=%0d v=%b ovr=%b expected i=%0d q=%0d v=1 ovr=0",
                         acc_i, acc_q, acc_valid, overrun, e.i, e.q);
            end
        end
        step(1);
        n_tests++;
        if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_accept: got v=%b expected 0", acc_valid); end
    endtask

    task automatic test_nco();
        bit ok;
        freq = 32'h2000_0000; ca_sel = 6'd0;
        restart(0, 1, 1'b1);
        wait_dump(EPOCH + 20, ok);
        n_tests++;
        if (!ok || last_i > 24 || last_i < -24 || last_q > 24 || last_q < -24) begin
            n_fail++;
            $display("FAIL nco_rotate: got i=%0d q=%0d expected both within +-24", last_i, last_q);
        end
    endtask

    task automatic test_random();
        int start, k;
        freq   = $urandom;
        ca_sel = 6'($urandom_range(0, 35));
        restart(int'($urandom_range(0, CL-1)), 2, 1'b1);
        start = n_dumps;
        k = 0;
        while (n_dumps - start < 2 && k < 3*EPOCH) begin
            step(137);
            k += 137;
            freq   = $urandom;
            ca_sel = 6'($urandom_range(0, 35));
        end
        n_tests++;
        if (n_dumps - start < 2) begin
            n_fail++; $display("FAIL random_dumps: got %0d dumps expected 2", n_dumps - start);
        end
    endtask

    initial begin
        gen_codes();
        test_reset();
        test_constant();
        test_matched();
        test_partial();
        test_backpressure();
        test_coincident();
        test_nco();
        test_random();
        enable = 1'b0;
        step(4);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d undelivered results expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
